// File: rtl/nb_dispatch_ctrl_pkg.sv
// Shared widths, position packet layout and dispatcher state encoding for the neighbour-filter path.
package nb_dispatch_ctrl_pkg;

  localparam int unsigned PARTICLE_ID_WIDTH = 8;
  localparam int unsigned NODE_ID_WIDTH     = 4;
  localparam int unsigned COORD_WIDTH       = 16;

  typedef struct packed {
    logic [PARTICLE_ID_WIDTH-1:0] parid;
    logic [COORD_WIDTH-1:0]       x;
    logic [COORD_WIDTH-1:0]       y;
    logic [COORD_WIDTH-1:0]       z;
  } pos_pkt_t;

  localparam int unsigned POS_PKT_STRUCT_WIDTH = $bits(pos_pkt_t);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    ISSUE,
    DRAIN
  } dispatch_state_t;

endpackage

// File: rtl/nb_dispatch_ctrl_filter_arbiter.sv
// Free-filter mask to one-hot grant. With NB_DISPATCH_RR_EN defined the search is round-robin,
// starting after the last filter granted; otherwise the lowest free index wins.
module nb_dispatch_ctrl_filter_arbiter #(
  parameter int unsigned NUM_FILTERS = 4
) (
`ifdef NB_DISPATCH_RR_EN
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   take_i,
`endif
  input  logic [NUM_FILTERS-1:0] free_i,
  output logic [NUM_FILTERS-1:0] grant_c
);

`ifdef NB_DISPATCH_RR_EN
  localparam int unsigned IDX_W = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;

  logic [IDX_W-1:0] ptr_q, ptr_d, idx;
  logic             found;

  always_comb begin
    grant_c = '0;
    ptr_d   = ptr_q;
    idx     = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < NUM_FILTERS; i++) begin
      idx = IDX_W'((32'(ptr_q) + i) % NUM_FILTERS);
      if (!found && free_i[idx]) begin
        found        = 1'b1;
        grant_c[idx] = 1'b1;
        if (take_i) ptr_d = IDX_W'((32'(idx) + 32'd1) % NUM_FILTERS);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  logic found;

  always_comb begin
    grant_c = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_FILTERS; i++) begin
      if (!found && free_i[i]) begin
        found      = 1'b1;
        grant_c[i] = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/nb_dispatch_ctrl.sv
// Neighbour dispatcher: sweeps the home ID, fetches neighbours from the nb cache and issues each to one
// free filter. Optional round-robin filter selection via NB_DISPATCH_RR_EN.
module nb_dispatch_ctrl
  import nb_dispatch_ctrl_pkg::*;
#(
  parameter int unsigned NUM_FILTERS   = 4,
  parameter int unsigned NB_ADDR_WIDTH = 7
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_start,
  input  logic [PARTICLE_ID_WIDTH-1:0]    i_home_count,
  input  logic [NB_ADDR_WIDTH:0]          i_nb_count,
  input  logic [NODE_ID_WIDTH-1:0]        i_nb_node_id,
  input  logic                            i_nb_from_home_cell_flag,
  output logic                            o_nb_rd_en,
  output logic [NB_ADDR_WIDTH-1:0]        o_nb_rd_addr,
  input  logic [POS_PKT_STRUCT_WIDTH-1:0] i_nb_rd_data,
  output logic [PARTICLE_ID_WIDTH-1:0]    o_home_parid,
  output logic [POS_PKT_STRUCT_WIDTH-1:0] o_nb_pos,
  output logic [NODE_ID_WIDTH-1:0]        o_nb_node_id,
  output logic                            o_nb_from_home_cell,
  output logic [NUM_FILTERS-1:0]          o_nb_valid,
  input  logic [NUM_FILTERS-1:0]          i_filtering_flag,
  input  logic [NUM_FILTERS-1:0]          i_back_pressure,
  output logic                            o_busy,
  output logic                            o_done
);

  localparam int unsigned CNT_W = NB_ADDR_WIDTH + 1;
  localparam int unsigned PID_W = PARTICLE_ID_WIDTH;

  dispatch_state_t                 state_q, state_d;
  logic [PID_W-1:0]                home_cnt_q, home_cnt_d, home_q, home_d;
  logic [CNT_W-1:0]                nb_cnt_q, nb_cnt_d, nb_idx_q, nb_idx_d;
  logic [NODE_ID_WIDTH-1:0]        node_q, node_d;
  logic                            from_home_q, from_home_d;
  logic [POS_PKT_STRUCT_WIDTH-1:0] pos_q, pos_d;
  logic                            rd_en_q, rd_en_d;
  logic [NB_ADDR_WIDTH-1:0]        rd_addr_q, rd_addr_d;
  logic [NUM_FILTERS-1:0]          valid_q, valid_d, free_c, grant_c;
  logic                            busy_q, busy_d, done_q, done_d;

  // A filter just strobed has not raised its flag yet, so our own valid shadows it.
  assign free_c = ~(i_filtering_flag | i_back_pressure | valid_q);

  nb_dispatch_ctrl_filter_arbiter #(
    .NUM_FILTERS(NUM_FILTERS)
  ) u_arb (
`ifdef NB_DISPATCH_RR_EN
    .clk    (clk),
    .rst_n  (rst_n),
    .take_i (state_q == ISSUE),
`endif
    .free_i (free_c),
    .grant_c(grant_c)
  );

  always_comb begin
    state_d     = state_q;
    home_cnt_d  = home_cnt_q;
    nb_cnt_d    = nb_cnt_q;
    nb_idx_d    = nb_idx_q;
    node_d      = node_q;
    from_home_d = from_home_q;
    pos_d       = pos_q;
    valid_d     = '0;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          home_cnt_d  = i_home_count;
          nb_cnt_d    = i_nb_count;
          node_d      = i_nb_node_id;
          from_home_d = i_nb_from_home_cell_flag;
          nb_idx_d    = '0;
          state_d     = (i_home_count == '0 || i_nb_count == '0) ? DRAIN : FETCH;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        pos_d   = i_nb_rd_data;
        state_d = ISSUE;
      end
      ISSUE: begin
        if (|free_c) begin
          valid_d  = grant_c;
          nb_idx_d = nb_idx_q + CNT_W'(1);
          state_d  = (nb_idx_d < nb_cnt_q) ? FETCH : DRAIN;
        end
      end
      DRAIN: begin
        if (&free_c) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d    = (state_d != IDLE);
    rd_en_d   = (state_d == FETCH);
    rd_addr_d = rd_en_d ? NB_ADDR_WIDTH'(nb_idx_d) : '0;

    // Home sweep never stalls: filters wait to see their captured ID come round again.
    if (state_q == IDLE || state_d == IDLE)
      home_d = '0;
    else if (({1'b0, home_q} + (PID_W + 1)'(1)) >= {1'b0, home_cnt_q})
      home_d = '0;
    else
      home_d = home_q + PID_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      home_cnt_q  <= '0;
      nb_cnt_q    <= '0;
      nb_idx_q    <= '0;
      node_q      <= '0;
      from_home_q <= 1'b0;
      pos_q       <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      home_q      <= '0;
      valid_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      home_cnt_q  <= home_cnt_d;
      nb_cnt_q    <= nb_cnt_d;
      nb_idx_q    <= nb_idx_d;
      node_q      <= node_d;
      from_home_q <= from_home_d;
      pos_q       <= pos_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      home_q      <= home_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign o_nb_rd_en          = rd_en_q;
  assign o_nb_rd_addr        = rd_addr_q;
  assign o_home_parid        = home_q;
  assign o_nb_pos            = pos_q;
  assign o_nb_node_id        = node_q;
  assign o_nb_from_home_cell = from_home_q;
  assign o_nb_valid          = valid_q;
  assign o_busy              = busy_q;
  assign o_done              = done_q;

endmodule

// File: doc/nb_dispatch_ctrl.md
Name: nb_dispatch_ctrl

Overview:
- Driving end of the neighbour-filter interface.
- Sweeps the shared home-particle ID broadcast every cycle, fetches neighbour particles from the nb position cache, and issues each one to exactly one free filter with a single-cycle valid strobe.
- Sits between the position caches and a bank of NUM_FILTERS filter FSMs.
- Declares a cell-pair job done once every neighbour has been issued and all filters have drained.

Parameters:
- NUM_FILTERS, 4, number of filter FSMs served (one-hot valid width).
- NB_ADDR_WIDTH, 7, nb cache address width; max 2^NB_ADDR_WIDTH neighbours per job.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  one-cycle pulse; begins a job when idle, ignored otherwise.
- i_home_count  in  PARTICLE_ID_WIDTH  valid home particles; sampled at i_start.
- i_nb_count  in  NB_ADDR_WIDTH+1  valid neighbours; sampled at i_start.
- i_nb_node_id  in  NODE_ID_WIDTH  source node of this job; sampled at i_start.
- i_nb_from_home_cell_flag  in  1  nb cell equals home cell; sampled at i_start.
- o_nb_rd_en  out  1  nb cache read strobe.
- o_nb_rd_addr  out  NB_ADDR_WIDTH  nb cache address.
- i_nb_rd_data  in  POS_PKT_STRUCT_WIDTH  cache data, valid 1 cycle after o_nb_rd_en.
- o_home_parid  out  PARTICLE_ID_WIDTH  home ID broadcast to all filters and the home cache.
- o_nb_pos  out  POS_PKT_STRUCT_WIDTH  shared nb payload.
- o_nb_node_id  out  NODE_ID_WIDTH  shared payload.
- o_nb_from_home_cell  out  1  shared payload.
- o_nb_valid  out  NUM_FILTERS  one-hot issue strobe.
- i_filtering_flag  in  NUM_FILTERS  per-filter busy.
- i_back_pressure  in  NUM_FILTERS  per-filter spinning.
- o_busy  out  1  job in progress.
- o_done  out  1  one-cycle job-complete pulse.

Behaviour:
- Reset: all outputs 0, counters 0, state IDLE.
- All outputs are registered.
- Home sweep, during any non-IDLE state:
  - o_home_parid increments every cycle and wraps from i_home_count-1 to 0.
  - It never stalls, including under back-pressure, because filters rely on seeing their captured ID again.
  - Held at 0 in IDLE.
- Filter k is free when i_filtering_flag[k]=0, i_back_pressure[k]=0 and o_nb_valid[k]=0. The o_nb_valid term shadows the one-cycle gap before the filter raises its flag.
- FSM:
  - IDLE: on i_start, latch counts and job fields, set o_busy=1 and nb_idx=0. Go to DRAIN if i_home_count==0 or i_nb_count==0, else FETCH.
  - FETCH: assert o_nb_rd_en with o_nb_rd_addr=nb_idx for one cycle, then go to LOAD.
  - LOAD: capture i_nb_rd_data into the staging register, then go to ISSUE.
  - ISSUE: if any filter is free, select one (lowest index by default), drive the staged payload and a one-hot o_nb_valid for exactly one cycle, and increment nb_idx. Then go to FETCH if nb_idx+1 < nb_count, else DRAIN. If no filter is free, hold ISSUE; payload stays stable.
  - DRAIN: wait until every filter is free, then pulse o_done for one cycle, clear o_busy and go to IDLE.
- The filter captures o_home_parid as it stands in the same cycle as its o_nb_valid bit.
- Issue throughput is at most one neighbour per 3 cycles.
- o_nb_valid has at most one bit set per cycle. It is never asserted outside ISSUE, and never to a filter that is back-pressured or filtering.
- i_nb_count = 2^NB_ADDR_WIDTH is legal; nb_idx is NB_ADDR_WIDTH+1 bits wide.
- i_home_count == 1: o_home_parid is constantly 0.
- i_start while busy is ignored. Count inputs may change after i_start without effect.
- Async reset mid-job aborts immediately with no o_done. Filters are reset by the same rst_n domain.

Optional Feature:
- Macro NB_DISPATCH_RR_EN.
- Defined: free-filter selection is round-robin, starting from the filter after the last one issued. The pointer resets to 0.
- Undefined: fixed priority, lowest free index wins.
- Interface is identical in both cases.

Decomposition:
- MD_pkg: PARTICLE_ID_WIDTH, POS_PKT_STRUCT_WIDTH and NODE_ID_WIDTH (already present), plus a dispatch_state_t enum {IDLE, FETCH, LOAD, ISSUE, DRAIN}.
- One natural sub-module, nb_filter_arbiter: combinational free mask to one-hot grant, containing the RR pointer register under NB_DISPATCH_RR_EN.

Test Plan:
- home_count=5, nb_count=3, all filters idle: o_home_parid cycles 0..4 with wrap; valids go to filters 0, 1, 2 in turn (default build); each pulse is 1 cycle and payload matches cache addresses 0..2; o_done follows once the flags drop.
- nb_count=0: o_done one cycle after DRAIN entry; no o_nb_rd_en or o_nb_valid.
- All filters filtering, one releases while o_nb_valid is held off: ISSUE stalls with a stable payload; the next issue goes to the released filter; o_home_parid keeps advancing throughout.
- Filter 0 with back_pressure=1: never receives o_nb_valid, even with flag=0; DRAIN holds o_done until back_pressure drops.
- RR build, 4 filters always free, nb_count=6: grants 0, 1, 2, 3, 0, 1.
- rst_n asserted during ISSUE: outputs 0 asynchronously; after release, state is IDLE; a new i_start runs cleanly.
